// File: rtl/bcd_score_ctrl.sv
// bcd_score_ctrl
// Score-update controller in front of one shared, pipelined BCD adder.
// It round-robin arbitrates add requests from NREQ point sources, starts
// the adder, counts the adder's latency internally, and owns the running
// BCD score. The score saturates at all nines, and a game-level clear
// zeroes it from any state.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   clear       zero score and sat (new game); any in-flight result is discarded
//   req         per-requester level request, held until ack
//   req_pts     per-requester BCD points, packed, requester i at [i*DIGITS*4 +: DIGITS*4]
//   ack         one-hot, one-cycle completion pulse
//   add_start   start pulse to the shared adder
//   add_a       adder operand A (score at grant)
//   add_b       adder operand B (granted points)
//   add_result  adder sum, valid on the last WAIT cycle
//   score       current BCD score
//   busy        controller not idle
//   sat         sticky saturation flag since last clear/reset
//
// state   | meaning
// IDLE    | arbitrate; on a grant latch operands and pointer
// ISSUE   | pulse add_start for one cycle
// WAIT    | count adder latency; capture the sum and ack on cnt == DIGITS

module bcd_score_ctrl #(
    parameter int DIGITS = 4,
    parameter int NREQ   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DIGITS*4-1:0] req_pts,
    output logic [NREQ-1:0]          ack,
    output logic                     add_start,
    output logic [DIGITS*4-1:0]      add_a,
    output logic [DIGITS*4-1:0]      add_b,
    input  logic [DIGITS*4-1:0]      add_result,
    output logic [DIGITS*4-1:0]      score,
    output logic                     busy,
    output logic                     sat
);

    localparam int W  = DIGITS * 4;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(DIGITS + 1);

    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] gnt_next;
    logic [IW-1:0] ptr_next;
    logic          gnt_valid;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          drop;
    logic          capture;
    logic          overflow;
    int            arb_idx;

    // Scan from the highest offset down so the requester closest to rr_ptr
    // is the one left standing.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_next  = '0;
        arb_idx   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            arb_idx = (int'(rr_ptr) + i) % NREQ;
            if (req[arb_idx]) begin
                gnt_valid = 1'b1;
                gnt_next  = IW'(arb_idx);
            end
        end
    end

    assign ptr_next = (int'(gnt_next) == NREQ - 1) ? '0 : gnt_next + IW'(1);

    assign capture = (state == S_WAIT) && (cnt == CW'(DIGITS));

    // With valid BCD digits a plain unsigned compare orders values exactly
    // like a digit-wise compare from the most significant digit down. A sum
    // smaller than the old score means the adder wrapped past all nines.
    assign overflow = (add_result < op_a);

    assign ack       = capture ? (NREQ'(1) << gnt_idx) : '0;
    assign add_start = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);
    assign add_a     = op_a;
    assign add_b     = op_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            op_a    <= '0;
            op_b    <= '0;
            score   <= '0;
            sat     <= 1'b0;
            drop    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        // A clear arriving with the grant means the add
                        // builds on the freshly cleared score.
                        op_a    <= clear ? '0 : score;
                        op_b    <= req_pts[int'(gnt_next)*W +: W];
                        gnt_idx <= gnt_next;
                        rr_ptr  <= ptr_next;
                        drop    <= 1'b0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= CW'(1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Clear beats a same-cycle capture; an add already past grant
            // keeps running so its ack still lands on schedule, but its sum
            // is thrown away.
            if (clear) begin
                score <= '0;
                sat   <= 1'b0;
                if (state != S_IDLE) begin
                    drop <= 1'b1;
                end
            end else if (capture && !drop) begin
                if (overflow) begin
                    score <= ALL_NINES;
                    sat   <= 1'b1;
                end else begin
                    score <= add_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_score_ctrl.sv
module tb_bcd_score_ctrl;

    localparam int DIGITS = 4;
    localparam int NREQ   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [3:0]  req;
    logic [63:0] req_pts;
    logic [3:0]  ack;
    logic        add_start;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_result;
    logic [15:0] score;
    logic        busy;
    logic        sat;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] cur_score;

    always #5 clk = ~clk;

    bcd_score_ctrl #(.DIGITS(DIGITS), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .req        (req),
        .req_pts    (req_pts),
        .ack        (ack),
        .add_start  (add_start),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .score      (score),
        .busy       (busy),
        .sat        (sat)
    );

    // Shared-adder model: sum is only valid DIGITS cycles after add_start,
    // otherwise it presents a junk value.
    function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        int c;
        int d;
        r = '0;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            d = int'(a[i*4 +: 4]) + int'(b[i*4 +: 4]) + c;
            if (d > 9) begin
                d = d - 10;
                c = 1;
            end else begin
                c = 0;
            end
            r[i*4 +: 4] = d[3:0];
        end
        return r;
    endfunction

    logic [15:0] pipe_sum = '0;
    int          pipe_cnt = 100;
    always @(posedge clk) begin
        if (add_start) begin
            pipe_sum <= bcd_add(add_a, add_b);
            pipe_cnt <= 1;
        end else if (pipe_cnt < 100) begin
            pipe_cnt <= pipe_cnt + 1;
        end
    end
    assign add_result = (pipe_cnt == DIGITS) ? pipe_sum : 16'h4321;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_score", score, 0);
        chk("clear_sat", sat, 0);
        cur_score = 16'h0000;
    endtask

    task automatic do_add(input int src, input logic [15:0] pts,
                          input logic [15:0] exp_score, input logic exp_sat);
        int   k;
        logic bad;
        @(negedge clk);
        req_pts[src*16 +: 16] = pts;
        req[src] = 1'b1;
        @(negedge clk);
        k = 1;
        chk("add_start", add_start, 1);
        chk("add_a", add_a, cur_score);
        chk("add_b", add_b, pts);
        bad = 1'b0;
        while (ack == 4'b0 && k < 20) begin
            @(negedge clk);
            k++;
            if (add_a !== cur_score || add_b !== pts) bad = 1'b1;
        end
        chk("operand_stable", bad, 0);
        chk("ack_latency", k, 1 + DIGITS);
        chk("ack_onehot", ack, 32'd1 << src);
        req[src] = 1'b0;
        @(negedge clk);
        chk("score", score, exp_score);
        chk("sat", sat, exp_sat);
        chk("ack_gone", ack, 0);
        chk("idle_after", busy, 0);
        cur_score = exp_score;
    endtask

    typedef struct {
        logic        clr;
        int          src;
        logic [15:0] pts;
        logic [15:0] exp_score;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   last;
        int   n;
        logic bad;

        vecs[0]  = '{1'b1, 0, 16'h0150, 16'h0150, 1'b0};
        vecs[1]  = '{1'b0, 1, 16'h0849, 16'h0999, 1'b0};
        vecs[2]  = '{1'b0, 2, 16'h0001, 16'h1000, 1'b0};
        vecs[3]  = '{1'b0, 3, 16'h0000, 16'h1000, 1'b0};
        vecs[4]  = '{1'b0, 0, 16'h8990, 16'h9990, 1'b0};
        vecs[5]  = '{1'b0, 1, 16'h0020, 16'h9999, 1'b1};
        vecs[6]  = '{1'b0, 2, 16'h0001, 16'h9999, 1'b1};
        vecs[7]  = '{1'b1, 3, 16'h0000, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 0, 16'h1234, 16'h1234, 1'b0};
        vecs[9]  = '{1'b0, 1, 16'h8765, 16'h9999, 1'b0};
        vecs[10] = '{1'b0, 2, 16'h0000, 16'h9999, 1'b0};
        vecs[11] = '{1'b1, 0, 16'h9999, 16'h9999, 1'b0};
        vecs[12] = '{1'b0, 3, 16'h0001, 16'h9999, 1'b1};

        rst = 1'b1;
        clear = 1'b0;
        req = '0;
        req_pts = '0;
        cur_score = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_score", score, 0);
        chk("rst_sat", sat, 0);
        chk("rst_ack", ack, 0);
        chk("rst_add_start", add_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].clr) do_clear();
            do_add(vecs[v].src, vecs[v].pts, vecs[v].exp_score, vecs[v].exp_sat);
        end

        // Clear during WAIT: result discarded, ack still on time.
        do_clear();
        do_add(0, 16'h0500, 16'h0500, 1'b0);
        @(negedge clk);
        req_pts[16 +: 16] = 16'h0100;
        req[1] = 1'b1;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("midclr_score", score, 0);
        chk("midclr_busy", busy, 1);
        @(negedge clk);
        chk("midclr_ack", ack, 4'b0010);
        req[1] = 1'b0;
        @(negedge clk);
        chk("midclr_score_after", score, 0);
        chk("midclr_sat_after", sat, 0);
        cur_score = 16'h0000;

        // Clear in the same cycle as capture: clear wins.
        do_add(2, 16'h0700, 16'h0700, 1'b0);
        @(negedge clk);
        req_pts[48 +: 16] = 16'h0200;
        req[3] = 1'b1;
        repeat (5) @(negedge clk);
        chk("capclr_ack", ack, 4'b1000);
        clear = 1'b1;
        req[3] = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        chk("capclr_score", score, 0);
        cur_score = 16'h0000;

        // Reset during WAIT.
        do_add(0, 16'h0300, 16'h0300, 1'b0);
        @(negedge clk);
        req_pts[32 +: 16] = 16'h0400;
        req[2] = 1'b1;
        @(negedge clk);
        chk("midrst_start", add_start, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_score", score, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_add_a", add_a, 0);
        chk("midrst_add_b", add_b, 0);
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack != 4'b0 || busy) bad = 1'b1;
        end
        chk("midrst_no_ack", bad, 0);
        cur_score = 16'h0000;

        // Round-robin with all requesters held.
        req_pts = {4{16'h0001}};
        req = 4'b1111;
        last = 0;
        n = 0;
        for (int c = 1; c <= 80 && n < 8; c++) begin
            @(negedge clk);
            if (n > 0 && c == last + 1) chk("rr_score", score, n);
            if (ack != 4'b0) begin
                chk("rr_order", ack, 32'd1 << (n % 4));
                chk("rr_gap", c - last, (n == 0) ? 1 + DIGITS : DIGITS + 2);
                last = c;
                n++;
            end
        end
        chk("rr_count", n, 8);
        req = '0;
        @(negedge clk);
        chk("rr_score_final", score, 16'h0008);
        chk("rr_sat", sat, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_score_ctrl.md
# bcd_score_ctrl

Score-update controller that shares the single pipelined BCD adder between up to NREQ point sources (asteroid hits, UFO hits, bonus events). It round-robin arbitrates add requests, sequences the adder over its multi-cycle latency, and owns the running BCD score register. It saturates the score at all-nines and supports an asynchronous-to-the-adder game-level clear.

## Interface
- DIGITS, 4: BCD digits in score and operands; must match the shared adder; ≥2
- NREQ, 4: number of requesters; ≥1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- clear  in  1  synchronous score clear (new game)
- req  in  NREQ  per-requester add request, level, held until ack
- req_pts  in  NREQ×DIGITS×4  points per requester, BCD, sampled at grant
- ack  out  NREQ  one-cycle completion pulse, one-hot
- add_start  out  1  start pulse to shared adder
- add_a  out  DIGITS×4  adder operand A (current score)
- add_b  out  DIGITS×4  adder operand B (granted points)
- add_result  in  DIGITS×4  adder sum
- score  out  DIGITS×4  current score, BCD
- busy  out  1  high in any state except IDLE
- sat  out  1  sticky: score has saturated since last clear/reset

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req, grant the first requester at or after rr_ptr (wrapping), latch score→op_a, req_pts[g]→op_b, g→gnt_idx; rr_ptr ← g+1 mod NREQ; go ISSUE. No req: stay.
- ISSUE (1 cycle): add_start=1; go WAIT, cnt←1.
- WAIT: cnt increments each cycle; at cnt==DIGITS (last WAIT cycle) add_result is valid: capture, pulse ack[gnt_idx], go IDLE.
- add_a/add_b drive op_a/op_b continuously; they stay stable from ISSUE through the last WAIT cycle.
- The adder's own done output is not used: its pipeline is not reset; latency is counted internally.
- Overflow: sum wrapped iff add_result < op_a (digit-wise BCD compare, MS digit first). On overflow score ← all 9s, sat ← 1; else score ← add_result.
- Zero points: valid; score unchanged, ack still pulsed.
- clear: score ← 0, sat ← 0 next edge, any state. If an add is in flight (ISSUE/WAIT, or capture in the same cycle), its result is discarded; FSM continues and ack still pulses on schedule. clear and capture same cycle: clear wins.
- req deasserted after grant: operation completes, ack still pulses.
- req_pts digits >9: undefined result, no checking.

## Timing
- Reset values: score=0, sat=0, ack=0, add_start=0, busy=0, add_a=add_b=0, rr_ptr=0, state IDLE.
- Req seen in IDLE cycle T → add_start in T+1 → ack in T+1+DIGITS → score updated visible T+2+DIGITS.
- Per-add occupancy DIGITS+2 cycles; back-to-back throughput one add per DIGITS+2 cycles (IDLE grant cycle re-entered after every ack).
- Requester may see ack and drop req same cycle; req still high in next IDLE is treated as a new request.
- rst mid-operation: everything to reset values next edge, no ack.

## Test plan
- Single add: DIGITS=4, score 0, req[0] with pts 0x0150 → add_start at T+1, ack[0] at T+5, score 0x0150 at T+6, sat=0.
- Carry ripple: score 0x0999, pts 0x0001 → score 0x1000 after ack, no saturation.
- Saturation: score 0x9990, pts 0x0020 → score 0x9999, sat=1; further add 0x0001 keeps 0x9999; clear → score 0, sat 0.
- Round-robin: req=4'b1111 held, each pts 0x0001 → acks in order 0,1,2,3,0…, each DIGITS+2 cycles apart, score increments by 1 per ack.
- Clear mid-flight: score 0x0500, add 0x0100 granted, clear during WAIT → score 0x0000 and remains 0 after ack; ack still pulses at T+1+DIGITS.
- Reset mid-flight: rst in WAIT → next cycle IDLE, score 0, no ack; operand stability check: add_a/add_b unchanged ISSUE→last WAIT in all tests.
